uart_stream_bridge: RTL and testbench
=====================================

Name: uart_stream_bridge

Overview:
- Downstream/host-side companion of the UART core. Drives the core's strobe interface (CSN/WEN/OEN/DATA_IN) and consumes its status and data outputs (TXRDY/RXRDY/DATA_OUT/PARITY_ERR/FRAMING_ERR/OVERFLOW).
- Converts that interface into two valid/ready byte streams: a TX stream in and an RX stream out with per-byte error flags.
- Arbitrates the single shared CSN between reads and writes.
- Buffers received bytes in a small queue so fabric back-pressure does not cause UART overflow.

Parameters:
- RXQ_DEPTH, 4: RX queue entries. Power of 2, range 2..16.
- HOLDOFF, 2: idle cycles after every core access before the next decision. Range 1..7. Covers the registered TXRDY/RXRDY update latency of the core.

Ports:
- CLK  in  1  system clock, same clock as the UART core
- RESET_N  in  1  asynchronous active-low reset
- tx_valid  in  1  upstream byte available
- tx_data  in  8  upstream byte
- tx_ready  out  1  bridge accepts tx_data this cycle
- rx_valid  out  1  head of RX queue valid
- rx_data  out  8  received byte
- rx_perr  out  1  parity error flag captured with the byte
- rx_ferr  out  1  framing error flag captured with the byte
- rx_ovf  out  1  core OVERFLOW sampled at read time
- rx_ready  in  1  downstream accepts head entry
- uart_csn  out  1  core chip select, active low
- uart_wen  out  1  core write enable, active low
- uart_oen  out  1  core output enable, active low
- uart_data_in  out  8  byte to core
- uart_txrdy  in  1  core TXRDY
- uart_rxrdy  in  1  core RXRDY
- uart_data_out  in  8  core DATA_OUT
- uart_parity_err  in  1  core PARITY_ERR
- uart_framing_err  in  1  core FRAMING_ERR
- uart_overflow  in  1  core OVERFLOW
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock CLK; reset RESET_N, asynchronous, active-low.
- Reset values:
  - uart_csn = uart_wen = uart_oen = 1; uart_data_in = 0.
  - tx_ready = 0; rx_valid = 0; rx_data/flags = 0; busy = 0.
  - Queue empty; FSM = IDLE; last_served = TX; holdoff counter = 0.
- All uart_* outputs are registered. Strobes are low for exactly one CLK cycle per access.
- FSM states: IDLE, WR, RD, WAIT.
- IDLE request conditions:
  - rx_req = uart_rxrdy & (queue count < RXQ_DEPTH).
  - tx_req = tx_valid & uart_txrdy.
- IDLE grant:
  - Only one request: grant it.
  - Both requests: grant the opposite of last_served (round robin).
  - No request: stay in IDLE.
- tx_ready is combinational and equals (state==IDLE) & tx_req & TX granted. A handshake at edge N latches tx_data into uart_data_in, moves to WR and sets last_served = TX.
- WR, during cycle N+1: uart_csn = 0, uart_wen = 0, uart_oen = 1. Next state is WAIT.
- RX grant at edge N: move to RD and set last_served = RX.
- RD, during cycle N+1: uart_csn = 0, uart_oen = 0, uart_wen = 1.
  - At the closing edge, push {uart_data_out, uart_parity_err, uart_framing_err, uart_overflow} into the queue.
  - These values are sampled while the strobe is low, before the core's clear takes effect.
  - Next state is WAIT.
- WAIT: counter loads HOLDOFF-1 on entry and decrements; returns to IDLE when it reaches 0. WAIT therefore lasts exactly HOLDOFF cycles, so the minimum access period is HOLDOFF+2 cycles.
- RX queue:
  - Circular buffer with read/write pointers of log2(RXQ_DEPTH) bits that wrap naturally. count has log2(RXQ_DEPTH)+1 bits.
  - rx_valid = (count != 0). The head entry drives rx_data/rx_perr/rx_ferr/rx_ovf combinationally from the buffer.
  - Pop on rx_valid & rx_ready.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - A full queue can never be pushed, because RD is entered only with space and at most one read is outstanding.
  - Pop on an empty queue is ignored.
- Back-pressure:
  - Full queue: RX requests are suppressed and the core holds RXRDY. The core's own overflow handling applies, and the next captured byte carries rx_ovf = 1.
  - uart_txrdy = 0: tx_ready stays 0.
- No combinational path from any uart_* input to any uart_* output.
- Asynchronous reset mid-access:
  - Strobes release immediately and the queue is flushed.
  - A byte mid-handshake on the TX side is dropped (it was already accepted).

Test Plan:
- Single TX:
  - Stimulus: tx_valid = 1, tx_data = 0xA5, uart_txrdy = 1, no RX.
  - Required: one cycle of csn = 0/wen = 0 with uart_data_in = 0xA5, one cycle after the tx_ready handshake; busy for 1+HOLDOFF cycles; next tx_ready no earlier than 3 cycles after the strobe (HOLDOFF = 2).
- Single RX:
  - Stimulus: uart_rxrdy = 1, uart_data_out = 0x3C, uart_parity_err = 1, rx_ready = 0.
  - Required: one cycle of csn = 0/oen = 0; rx_valid = 1 the cycle after the strobe with rx_data = 0x3C, rx_perr = 1, rx_ferr = 0, rx_ovf = 0; entry held until rx_ready = 1.
- Arbitration:
  - Stimulus: rx_req and tx_req both asserted continuously from reset.
  - Required: access order RD, WR, RD, WR…; every access is separated by exactly HOLDOFF idle cycles.
- Queue full (RXQ_DEPTH = 4):
  - Stimulus: rx_ready = 0 with uart_rxrdy held at 1.
  - Required: exactly 4 reads occur, then no further oen strobe; after one pop, exactly one more read occurs; entries pop in FIFO order with correct data through pointer wrap across 10 bytes.
- Simultaneous push/pop:
  - Stimulus: rx_ready = 1 while bytes 0x01..0x08 arrive back to back.
  - Required: count never exceeds 1 and the output order is 0x01..0x08.
- Reset mid-RD:
  - Stimulus: RESET_N low during the oen strobe cycle.
  - Required: uart_oen and uart_csn return to 1 immediately; rx_valid = 0; after release the FSM is in IDLE and the first grant goes to RX.

Source files
------------

// File: rtl/uart_stream_bridge.sv
`default_nettype none
// ==========================================================================
// uart_stream_bridge : valid/ready TX/RX byte streams over the UART core bus
// Rev 1.0
// ==========================================================================
module uart_stream_bridge #(
  parameter int RXQ_DEPTH = 4,
  parameter int HOLDOFF   = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_ovf,
  input  logic       rx_ready,
  output logic       uart_csn,
  output logic       uart_wen,
  output logic       uart_oen,
  output logic [7:0] uart_data_in,
  input  logic       uart_txrdy,
  input  logic       uart_rxrdy,
  input  logic [7:0] uart_data_out,
  input  logic       uart_parity_err,
  input  logic       uart_framing_err,
  input  logic       uart_overflow,
  output logic       busy
);

  localparam int AW = $clog2(RXQ_DEPTH);
  localparam logic [AW:0] c_full      = RXQ_DEPTH[AW:0];
  localparam logic [2:0]  c_hold_load = 3'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_rx;
  logic          r_run;
  logic [2:0]    r_hold;
  logic [10:0]   r_mem [RXQ_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_rx_req;
  logic          w_tx_req;
  logic          w_grant_tx;
  logic          w_grant_rx;
  logic          w_push;
  logic          w_pop;

  // r_run keeps both grants (and tx_ready) low while reset is held
  always_comb begin
    w_rx_req   = r_run & uart_rxrdy & (r_count != c_full);
    w_tx_req   = r_run & tx_valid & uart_txrdy;
    w_grant_tx = w_tx_req & (~w_rx_req | r_last_rx);
    w_grant_rx = w_rx_req & (~w_tx_req | ~r_last_rx);
    tx_ready   = (r_state == S_IDLE) & w_grant_tx;
    busy       = (r_state != S_IDLE);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_tx)      w_state_nxt = S_WR;
        else if (w_grant_rx) w_state_nxt = S_RD;
      end
      S_WR, S_RD: w_state_nxt = S_WAIT;
      S_WAIT:     if (r_hold == 3'd0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_last_rx    <= 1'b0;
      r_run        <= 1'b0;
      r_hold       <= 3'd0;
      uart_csn     <= 1'b1;
      uart_wen     <= 1'b1;
      uart_oen     <= 1'b1;
      uart_data_in <= 8'h00;
    end else begin
      r_run    <= 1'b1;
      r_state  <= w_state_nxt;
      // strobes follow the next state so they are low for exactly the WR/RD cycle
      uart_csn <= ~((w_state_nxt == S_WR) | (w_state_nxt == S_RD));
      uart_wen <= ~(w_state_nxt == S_WR);
      uart_oen <= ~(w_state_nxt == S_RD);
      if (tx_ready) begin
        uart_data_in <= tx_data;
        r_last_rx    <= 1'b0;
      end else if ((r_state == S_IDLE) & w_grant_rx) begin
        r_last_rx    <= 1'b1;
      end
      if ((w_state_nxt == S_WAIT) && (r_state != S_WAIT))
        r_hold <= c_hold_load;
      else if ((r_state == S_WAIT) && (r_hold != 3'd0))
        r_hold <= r_hold - 3'd1;
    end
  end

  assign w_push = (r_state == S_RD);
  assign w_pop  = (r_count != '0) & rx_ready;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < RXQ_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {uart_data_out, uart_parity_err, uart_framing_err, uart_overflow};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_valid = (r_count != '0);
  assign {rx_data, rx_perr, rx_ferr, rx_ovf} = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_uart_stream_bridge.sv
`default_nettype none
// Scoreboard bench: a queue-based UART core stand-in feeds the bridge, and
// monitors compare every strobe and every popped RX entry against FIFO order.
module tb_uart_stream_bridge;
  localparam int H = 2;
  localparam int D = 4;

  logic       CLK, RESET_N;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_data, rx_data, uart_data_in, uart_data_out;
  logic       rx_perr, rx_ferr, rx_ovf;
  logic       uart_csn, uart_wen, uart_oen, uart_txrdy, uart_rxrdy;
  logic       uart_parity_err, uart_framing_err, uart_overflow, busy;

  uart_stream_bridge #(.RXQ_DEPTH(D), .HOLDOFF(H)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_ovf(rx_ovf), .rx_ready(rx_ready),
    .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
    .uart_data_in(uart_data_in), .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_data_out(uart_data_out), .uart_parity_err(uart_parity_err),
    .uart_framing_err(uart_framing_err), .uart_overflow(uart_overflow),
    .busy(busy)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [7:0]  tx_src[$];
  logic [7:0]  tx_exp[$];
  logic [10:0] core_q[$];
  logic [10:0] rx_exp[$];
  bit          acc_log[$];
  bit          rd_pending = 1'b0;
  bit          strict_gap = 1'b0;
  int          last_acc   = -1;
  int          last_hs    = -10;
  bit          drv_hs, mon_wr;
  logic [7:0]  mon_exp_b;
  logic [10:0] mon_got, mon_exp_e;
  int          hs1, hs2, busy_n, reads, n, k, vcnt;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // core stand-in: RXRDY while bytes are pending, head byte on DATA_OUT
  function automatic void drive_core();
    uart_rxrdy = (core_q.size() != 0);
    if (core_q.size() != 0)
      {uart_data_out, uart_parity_err, uart_framing_err, uart_overflow} = core_q[0];
    else
      {uart_data_out, uart_parity_err, uart_framing_err, uart_overflow} = 11'h000;
  endfunction

  function automatic void add_rx(input logic [10:0] e);
    core_q.push_back(e);
    rx_exp.push_back(e);
    drive_core();
  endfunction

  // core clears the read byte just after the strobe's closing edge
  initial forever begin
    @(posedge CLK);
    #1;
    if (rd_pending) begin
      rd_pending = 1'b0;
      void'(core_q.pop_front());
      drive_core();
    end
  end

  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge CLK);
      drv_hs = RESET_N && tx_valid && tx_ready;
      @(posedge CLK);
      #1;
      if (drv_hs && tx_src.size() != 0) void'(tx_src.pop_front());
      tx_valid = (tx_src.size() != 0);
      tx_data  = tx_valid ? tx_src[0] : 8'h00;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (!RESET_N) begin
      last_acc = -1;
    end else begin
      if (!uart_csn) begin
        mon_wr = !uart_wen;
        check(uart_wen != uart_oen, "strobe_kind", 32'({uart_wen, uart_oen}),
              mon_wr ? 32'h1 : 32'h2);
        if (last_acc >= 0) begin
          check(cyc - last_acc >= H + 2, "access_gap_min", cyc - last_acc, H + 2);
          if (strict_gap) check(cyc - last_acc == H + 2, "access_gap_exact", cyc - last_acc, H + 2);
        end
        last_acc = cyc;
        acc_log.push_back(!mon_wr);
        if (mon_wr) begin
          check(tx_exp.size() != 0, "tx_write_expected", 32'(uart_data_in), 0);
          if (tx_exp.size() != 0) begin
            mon_exp_b = tx_exp.pop_front();
            check(uart_data_in == mon_exp_b, "tx_data", 32'(uart_data_in), 32'(mon_exp_b));
          end
          check(cyc == last_hs + 1, "tx_strobe_latency", cyc - last_hs, 1);
        end else begin
          rd_pending = 1'b1;
        end
      end
      if (rx_valid && rx_ready) begin
        mon_got = {rx_data, rx_perr, rx_ferr, rx_ovf};
        check(rx_exp.size() != 0, "rx_entry_expected", 32'(mon_got), 0);
        if (rx_exp.size() != 0) begin
          mon_exp_e = rx_exp.pop_front();
          check(mon_got == mon_exp_e, "rx_entry", 32'(mon_got), 32'(mon_exp_e));
        end
      end
      if (tx_valid && tx_ready) begin
        tx_exp.push_back(tx_data);
        last_hs = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit drained();
    return tx_src.size() == 0 && core_q.size() == 0 && rx_exp.size() == 0 &&
           tx_exp.size() == 0 && !busy && !rx_valid;
  endfunction

  task automatic drain(input int bound, input bit rnd, input string name);
    int i = 0;
    while (!drained() && i < bound) begin
      tick();
      if (rnd) begin
        rx_ready   = 1'($urandom_range(0, 1));
        uart_txrdy = 1'($urandom_range(0, 1));
      end
      i++;
    end
    check(i < bound, name, i, bound);
  endtask

  task automatic wait_hs(input int bound, output int c);
    int i = 0;
    c = -1;
    while (i < bound && c < 0) begin
      @(negedge CLK);
      i++;
      if (tx_valid && tx_ready) c = cyc;
    end
    check(c >= 0, "tx_handshake_timeout", i, bound);
  endtask

  initial begin
    RESET_N    = 1'b0;
    rx_ready   = 1'b0;
    uart_txrdy = 1'b0;
    drive_core();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check({uart_csn, uart_wen, uart_oen} == 3'b111, "rst_strobes", 32'({uart_csn, uart_wen, uart_oen}), 7);
    check(uart_data_in == 8'h00, "rst_data_in", 32'(uart_data_in), 0);
    check(!tx_ready, "rst_tx_ready", 32'(tx_ready), 0);
    check(!rx_valid, "rst_rx_valid", 32'(rx_valid), 0);
    check({rx_data, rx_perr, rx_ferr, rx_ovf} == 11'h0, "rst_rx_entry",
          32'({rx_data, rx_perr, rx_ferr, rx_ovf}), 0);
    check(!busy, "rst_busy", 32'(busy), 0);
    tick();
    RESET_N = 1'b1;

    // single TX followed by a second byte to measure the reissue spacing
    uart_txrdy = 1'b1;
    tx_src.push_back(8'hA5);
    tx_src.push_back(8'h5A);
    wait_hs(30, hs1);
    busy_n = 0;
    n = 0;
    do begin
      @(negedge CLK);
      if (busy) busy_n++;
      n++;
    end while (busy && n < 20);
    check(busy_n == 1 + H, "tx_busy_cycles", busy_n, 1 + H);
    check(tx_ready, "tx_ready_after_holdoff", 32'(tx_ready), 1);
    hs2 = cyc;
    check(hs2 - hs1 == H + 2, "tx_reissue_spacing", hs2 - hs1, H + 2);
    drain(50, 1'b0, "tx_drain");

    // single RX held until accepted
    uart_txrdy = 1'b0;
    rx_ready   = 1'b0;
    add_rx({8'h3C, 1'b1, 1'b0, 1'b0});
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (uart_oen && n < 20);
    check(!uart_oen && !uart_csn, "rx_strobe_seen", 32'({uart_csn, uart_oen}), 0);
    @(negedge CLK);
    check(rx_valid, "rx_valid_after_strobe", 32'(rx_valid), 1);
    check({rx_data, rx_perr, rx_ferr, rx_ovf} == {8'h3C, 3'b100}, "rx_head",
          32'({rx_data, rx_perr, rx_ferr, rx_ovf}), 32'({8'h3C, 3'b100}));
    repeat (5) @(negedge CLK);
    check(rx_valid && rx_data == 8'h3C, "rx_hold", 32'({rx_valid, rx_data}), 32'h13C);
    tick();
    rx_ready = 1'b1;
    drain(50, 1'b0, "rx_drain");

    // arbitration with both requests present from reset
    tick();
    RESET_N = 1'b0;
    for (int i = 0; i < 5; i++) begin
      add_rx(11'($urandom));
      tx_src.push_back(8'($urandom));
    end
    uart_txrdy = 1'b1;
    rx_ready   = 1'b1;
    acc_log.delete();
    strict_gap = 1'b1;
    tick();
    tick();
    RESET_N = 1'b1;
    drain(300, 1'b0, "arb_drain");
    strict_gap = 1'b0;
    check(acc_log.size() == 10, "arb_access_count", acc_log.size(), 10);
    for (int i = 0; i < acc_log.size(); i++)
      check(acc_log[i] == ((i % 2) == 0), "arb_order", 32'(acc_log[i]), 32'((i % 2) == 0));

    // queue full: ten bytes through a four-entry queue
    uart_txrdy = 1'b0;
    rx_ready   = 1'b0;
    for (int i = 0; i < 10; i++) add_rx(11'($urandom));
    reads = 0;
    repeat (40) begin
      @(negedge CLK);
      if (!uart_csn && !uart_oen) reads++;
    end
    check(reads == D, "qfull_reads", reads, D);
    check(rx_valid, "qfull_valid", 32'(rx_valid), 1);
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    reads = 0;
    repeat (30) begin
      @(negedge CLK);
      if (!uart_csn && !uart_oen) reads++;
    end
    check(reads == 1, "qfull_refill_reads", reads, 1);
    drain(400, 1'b1, "qfull_drain");

    // streaming with a always-ready sink: each byte visible for one cycle
    uart_txrdy = 1'b0;
    rx_ready   = 1'b1;
    for (int i = 1; i <= 8; i++) add_rx({8'(i), 3'($urandom)});
    vcnt = 0;
    n = 0;
    while (!drained() && n < 200) begin
      @(negedge CLK);
      if (rx_valid) vcnt++;
      n++;
    end
    check(vcnt == 8, "stream_valid_cycles", vcnt, 8);

    // random mix of both directions with random back-pressure
    for (int i = 0; i < 12; i++) begin
      add_rx(11'($urandom));
      tx_src.push_back(8'($urandom));
    end
    drain(2000, 1'b1, "mix_drain");

    // reset while the second read strobe is low
    rx_ready   = 1'b0;
    uart_txrdy = 1'b1;
    add_rx({8'h77, 3'b010});
    add_rx({8'h99, 3'b001});
    n = 0;
    k = 0;
    while (k < 2 && n < 60) begin
      tick();
      n++;
      if (!uart_oen) k++;
    end
    check(k == 2, "rst_rd_reached", k, 2);
    RESET_N = 1'b0;
    if (rx_exp.size() != 0) void'(rx_exp.pop_front());
    tx_src.push_back(8'h88);
    #1;
    check(uart_oen && uart_csn, "rst_mid_rd_strobes", 32'({uart_csn, uart_oen}), 3);
    check(!rx_valid, "rst_mid_rd_flush", 32'(rx_valid), 0);
    check(!busy, "rst_mid_rd_idle", 32'(busy), 0);
    tick();
    tick();
    RESET_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (uart_csn && n < 20);
    check(!uart_csn && !uart_oen, "rst_first_grant_rx", 32'({uart_csn, uart_oen}), 0);
    tick();
    rx_ready = 1'b1;
    drain(100, 1'b0, "rst_drain");

    check(tx_exp.size() == 0, "tx_leftover", tx_exp.size(), 0);
    check(rx_exp.size() == 0, "rx_leftover", rx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
